rvv_seg_uop_sequencer: RTL and testbench
========================================

// Module: rvv_seg_uop_sequencer
// PURPOSE
//  Splits one segment load/store (VLSEG/VSSEG/VLSSEG/VSSSEG) into per-register uops for the LSU uop queue.
//  Sits between RVV decode and the LSU; one instruction in, NF*EFF_REGS uops out, one per accepted cycle.
//  Checks the register-group legality and skips registers wholly beyond vl.
// PARAMETERS
//  VLENB  16  bytes per vector register
//  VLW    8   width of vl / element indices (holds VLENB*8)
// PORTS
//  clk            in   1    clock
//  rst            in   1    async reset, active-high
//  flush          in   1    sync flush: drop current instruction
//  inst_valid     in   1    instruction offered
//  inst_ready     out  1    sequencer can accept (state IDLE)
//  inst_vd        in   5    base vector register
//  inst_nf        in   3    fields minus 1 (NF = inst_nf+1)
//  inst_eew       in   2    0=8b, 1=16b, 2=32b, 3=reserved
//  inst_emul      in   2    EMUL: 0=1, 1=2, 2=4, 3=8 (fractional coded as 0)
//  inst_vl        in   VLW  active element count
//  inst_is_store  in   1    1=store, 0=load
//  inst_illegal   out  1    one-cycle pulse: accepted instruction rejected
//  uop_valid      out  1    uop offered
//  uop_ready      in   1    LSU accepts uop
//  uop_vd         out  5    target/source register
//  uop_field      out  3    field index 0..NF-1
//  uop_elem_start out  VLW  first element index in this register
//  uop_elem_cnt   out  VLW  elements in this uop (1..EPR)
//  uop_is_store   out  1    copy of inst_is_store
//  uop_last       out  1    final uop of the instruction
//  busy           out  1    state ISSUE
// BEHAVIOUR
//  Reset (async): state IDLE, uop_valid=0, inst_illegal=0, counters f=r=0, all uop_* fields 0.
//  EPR = VLENB>>eew. EMULN = 1<<emul. EFF_REGS = min(EMULN, ceil(vl/EPR)).
//  Illegal if eew==3, NF*EMULN>8, or vd+NF*EMULN>32 (6-bit compare, no wrap).
//  FSM IDLE: inst_ready=1. On inst_valid:
//   - illegal -> stay IDLE, inst_illegal=1 next cycle only, no uops.
//   - vl==0 -> stay IDLE, no uops, no pulse.
//   - else latch fields, f=r=0, go ISSUE; first uop_valid at accept+1.
//  FSM ISSUE: inst_ready=0; uop_valid=1.
//   uop_vd=vd+f*EMULN+r; uop_elem_start=r*EPR; uop_elem_cnt=min(EPR, vl-r*EPR).
//   Order: r inner (0..EFF_REGS-1), f outer (0..NF-1).
//   On uop_valid&&uop_ready: r==EFF_REGS-1 -> r=0,f++; else r++.
//   uop_last=(f==NF-1)&&(r==EFF_REGS-1); last handshake -> IDLE, inst_ready=1 next cycle.
//   Back-to-back throughput: 1 uop/cycle while uop_ready=1; IDLE cycle between instructions.
//  Stall: while uop_valid&&!uop_ready all uop_* outputs hold stable.
//  flush: any state -> IDLE next cycle, uop_valid=0, counters cleared; wins over handshake and accept.
//  Reset mid-sequence: uop_valid drops immediately (async); nothing replayed.
//  Arithmetic: element math in VLW bits, register math in 6 bits; results fit by legality.
// TESTING (VLENB=16)
//  nf=1,eew=0,emul=1,vd=4,vl=20 -> uops (vd,f,start,cnt): (4,0,0,16)(5,0,16,4)(6,1,0,16)(7,1,16,4,last).
//  eew=2,emul=1,nf=0,vd=8,vl=5 -> (8,0,0,4)(9,0,4,1,last); emul=3,vl=5 -> same 2 uops, regs 10..15 skipped.
//  uop_ready low 3 cycles at 2nd uop -> fields unchanged 3 cycles, sequence resumes, 4 uops total.
//  nf=7,emul=1 -> inst_illegal pulse 1 cycle, no uop; vd=30,nf=2,emul=0 -> illegal; eew=3 -> illegal.
//  vl=0 -> accepted, no uop_valid, inst_ready stays 1.
//  flush after 1st uop -> IDLE next cycle; rst asserted mid-ISSUE -> uop_valid=0 same cycle, busy=0.

Source files
------------

// File: rtl/rvv_seg_uop_sequencer.sv
// Segment load/store uop sequencer: expands one VLSEG/VSSEG-class instruction into
// NF x EFF_REGS per-register LSU uops, skipping registers wholly beyond vl.
module rvv_seg_uop_sequencer #(
    parameter int VLENB = 16,
    parameter int VLW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           inst_valid,
    output logic           inst_ready,
    input  logic [4:0]     inst_vd,
    input  logic [2:0]     inst_nf,
    input  logic [1:0]     inst_eew,
    input  logic [1:0]     inst_emul,
    input  logic [VLW-1:0] inst_vl,
    input  logic           inst_is_store,
    output logic           inst_illegal,
    output logic           uop_valid,
    input  logic           uop_ready,
    output logic [4:0]     uop_vd,
    output logic [2:0]     uop_field,
    output logic [VLW-1:0] uop_elem_start,
    output logic [VLW-1:0] uop_elem_cnt,
    output logic           uop_is_store,
    output logic           uop_last,
    output logic           busy
);

    localparam int LOG2_VLENB = $clog2(VLENB);
    localparam int CW         = VLW + 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    function automatic logic [VLW-1:0] sat_cnt(input logic [VLW-1:0] vl,
                                               input logic [VLW-1:0] start,
                                               input logic [VLW-1:0] epr);
        logic [VLW-1:0] rem;
        rem = vl - start;
        return (rem < epr) ? rem : epr;
    endfunction

    // Legality guarantees the register index stays below 32, so 5-bit wrap never occurs.
    function automatic logic [4:0] reg_idx(input logic [4:0] vd, input logic [2:0] f,
                                           input logic [3:0] emuln, input logic [2:0] r);
        return vd + ({2'b00, f} * {1'b0, emuln}) + {2'b00, r};
    endfunction

    function automatic logic [VLW-1:0] elem_start(input logic [2:0] r,
                                                  input logic [VLW-1:0] epr);
        return {{(VLW-3){1'b0}}, r} * epr;
    endfunction

    // Decode of the offered instruction
    logic [3:0]     in_emuln;
    logic [VLW-1:0] in_epr;
    logic [3:0]     in_nf1;
    logic [6:0]     in_nfemul;
    logic [6:0]     in_vdend;
    logic           in_illegal;
    logic [3:0]     in_eshift;
    logic [CW-1:0]  in_ceil;
    logic [3:0]     in_eff;

    always_comb begin
        in_emuln   = 4'd1 << inst_emul;
        in_epr     = VLW'(VLENB) >> inst_eew;
        in_nf1     = {1'b0, inst_nf} + 4'd1;
        in_nfemul  = {3'b000, in_nf1} * {3'b000, in_emuln};
        in_vdend   = {2'b00, inst_vd} + in_nfemul;
        in_illegal = (inst_eew == 2'd3) || (in_nfemul > 7'd8) || (in_vdend > 7'd32);
        in_eshift  = 4'(LOG2_VLENB) - {2'b00, inst_eew};
        in_ceil    = ({1'b0, inst_vl} + {1'b0, in_epr} - CW'(1)) >> in_eshift;
        in_eff     = (in_ceil < CW'(in_emuln)) ? in_ceil[3:0] : in_emuln;
    end

    state_e         state_q, state_d;
    logic [4:0]     vd_q, vd_d;
    logic [2:0]     nf_q, nf_d;
    logic [3:0]     emuln_q, emuln_d;
    logic [VLW-1:0] epr_q, epr_d;
    logic [VLW-1:0] vl_q, vl_d;
    logic [3:0]     eff_q, eff_d;
    logic [2:0]     f_q, f_d;
    logic [2:0]     r_q, r_d;
    logic           valid_q, valid_d;
    logic           illegal_q, illegal_d;
    logic [4:0]     uvd_q, uvd_d;
    logic [VLW-1:0] ustart_q, ustart_d;
    logic [VLW-1:0] ucnt_q, ucnt_d;
    logic           ustore_q, ustore_d;
    logic           ulast_q, ulast_d;

    logic           wrap;
    logic [2:0]     fn, rn;

    always_comb begin
        state_d   = state_q;
        vd_d      = vd_q;
        nf_d      = nf_q;
        emuln_d   = emuln_q;
        epr_d     = epr_q;
        vl_d      = vl_q;
        eff_d     = eff_q;
        f_d       = f_q;
        r_d       = r_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        uvd_d     = uvd_q;
        ustart_d  = ustart_q;
        ucnt_d    = ucnt_q;
        ustore_d  = ustore_q;
        ulast_d   = ulast_q;

        wrap = ({1'b0, r_q} == (eff_q - 4'd1));
        fn   = wrap ? (f_q + 3'd1) : f_q;
        rn   = wrap ? 3'd0 : (r_q + 3'd1);

        if (flush) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            f_d      = '0;
            r_d      = '0;
            uvd_d    = '0;
            ustart_d = '0;
            ucnt_d   = '0;
            ustore_d = 1'b0;
            ulast_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_valid) begin
                        if (in_illegal) begin
                            illegal_d = 1'b1;
                        end else if (inst_vl != '0) begin
                            state_d  = ISSUE;
                            vd_d     = inst_vd;
                            nf_d     = inst_nf;
                            emuln_d  = in_emuln;
                            epr_d    = in_epr;
                            vl_d     = inst_vl;
                            eff_d    = in_eff;
                            f_d      = '0;
                            r_d      = '0;
                            valid_d  = 1'b1;
                            uvd_d    = inst_vd;
                            ustart_d = '0;
                            ucnt_d   = sat_cnt(inst_vl, '0, in_epr);
                            ustore_d = inst_is_store;
                            ulast_d  = (inst_nf == 3'd0) && (in_eff == 4'd1);
                        end
                    end
                end
                ISSUE: begin
                    if (uop_ready) begin
                        if (ulast_q) begin
                            state_d  = IDLE;
                            valid_d  = 1'b0;
                            f_d      = '0;
                            r_d      = '0;
                            uvd_d    = '0;
                            ustart_d = '0;
                            ucnt_d   = '0;
                            ustore_d = 1'b0;
                            ulast_d  = 1'b0;
                        end else begin
                            f_d      = fn;
                            r_d      = rn;
                            uvd_d    = reg_idx(vd_q, fn, emuln_q, rn);
                            ustart_d = elem_start(rn, epr_q);
                            ucnt_d   = sat_cnt(vl_q, elem_start(rn, epr_q), epr_q);
                            ulast_d  = (fn == nf_q) && ({1'b0, rn} == (eff_q - 4'd1));
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vd_q      <= '0;
            nf_q      <= '0;
            emuln_q   <= '0;
            epr_q     <= '0;
            vl_q      <= '0;
            eff_q     <= '0;
            f_q       <= '0;
            r_q       <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            uvd_q     <= '0;
            ustart_q  <= '0;
            ucnt_q    <= '0;
            ustore_q  <= 1'b0;
            ulast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vd_q      <= vd_d;
            nf_q      <= nf_d;
            emuln_q   <= emuln_d;
            epr_q     <= epr_d;
            vl_q      <= vl_d;
            eff_q     <= eff_d;
            f_q       <= f_d;
            r_q       <= r_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            uvd_q     <= uvd_d;
            ustart_q  <= ustart_d;
            ucnt_q    <= ucnt_d;
            ustore_q  <= ustore_d;
            ulast_q   <= ulast_d;
        end
    end

    assign inst_ready     = (state_q == IDLE);
    assign busy           = (state_q == ISSUE);
    assign inst_illegal   = illegal_q;
    assign uop_valid      = valid_q;
    assign uop_vd         = uvd_q;
    assign uop_field      = f_q;
    assign uop_elem_start = ustart_q;
    assign uop_elem_cnt   = ucnt_q;
    assign uop_is_store   = ustore_q;
    assign uop_last       = ulast_q;

endmodule

// File: tb/tb_rvv_seg_uop_sequencer.sv
// Directed bench for rvv_seg_uop_sequencer (VLENB=16): vector table plus stall,
// flush and mid-sequence reset sequences.
module tb_rvv_seg_uop_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       inst_valid = 1'b0;
    logic       inst_ready;
    logic [4:0] inst_vd = '0;
    logic [2:0] inst_nf = '0;
    logic [1:0] inst_eew = '0;
    logic [1:0] inst_emul = '0;
    logic [7:0] inst_vl = '0;
    logic       inst_is_store = 1'b0;
    logic       inst_illegal;
    logic       uop_valid;
    logic       uop_ready = 1'b1;
    logic [4:0] uop_vd;
    logic [2:0] uop_field;
    logic [7:0] uop_elem_start;
    logic [7:0] uop_elem_cnt;
    logic       uop_is_store;
    logic       uop_last;
    logic       busy;

    rvv_seg_uop_sequencer #(.VLENB(16), .VLW(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_vd(inst_vd), .inst_nf(inst_nf), .inst_eew(inst_eew), .inst_emul(inst_emul),
        .inst_vl(inst_vl), .inst_is_store(inst_is_store), .inst_illegal(inst_illegal),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_vd(uop_vd), .uop_field(uop_field),
        .uop_elem_start(uop_elem_start), .uop_elem_cnt(uop_elem_cnt),
        .uop_is_store(uop_is_store), .uop_last(uop_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] vd;
        logic [2:0] nf;
        logic [1:0] eew;
        logic [1:0] emul;
        logic [7:0] vl;
        logic       st;
        logic       ill;
        int         n;
        int         vd0;
        int         vdl;
        int         cntl;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] vd, input logic [2:0] nf, input logic [1:0] eew,
                         input logic [1:0] emul, input logic [7:0] vl, input logic st);
        inst_vd = vd; inst_nf = nf; inst_eew = eew; inst_emul = emul;
        inst_vl = vl; inst_is_store = st;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
    endtask

    // Consumes uops (uop_ready held high) until uop_last is taken or maxc cycles pass.
    task automatic collect(input int maxc, input logic st, output int n, output int vd0,
                           output int vdl, output int cntl, output bit last_seen,
                           output bit st_ok);
        n = 0; vd0 = -1; vdl = -1; cntl = -1; last_seen = 0; st_ok = 1;
        for (int c = 0; c < maxc; c++) begin
            if (uop_valid) begin
                if (n == 0) vd0 = int'(uop_vd);
                vdl  = int'(uop_vd);
                cntl = int'(uop_elem_cnt);
                if (uop_is_store != st) st_ok = 0;
                n++;
                if (uop_last) begin
                    last_seen = 1;
                    step();
                    break;
                end
            end
            step();
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int n, vd0, vdl, cntl;
        bit ls, sok;
        issue(v.vd, v.nf, v.eew, v.emul, v.vl, v.st);
        chk($sformatf("v%0d_illegal", i), int'(inst_illegal), int'(v.ill));
        if (v.n == 0) begin
            chk($sformatf("v%0d_ready", i), int'(inst_ready), 1);
            collect(4, v.st, n, vd0, vdl, cntl, ls, sok);
            chk($sformatf("v%0d_nuops", i), n, 0);
            chk($sformatf("v%0d_illegal_drop", i), int'(inst_illegal), 0);
        end else begin
            collect(40, v.st, n, vd0, vdl, cntl, ls, sok);
            chk($sformatf("v%0d_nuops", i), n, v.n);
            chk($sformatf("v%0d_last_seen", i), int'(ls), 1);
            chk($sformatf("v%0d_vd_first", i), vd0, v.vd0);
            chk($sformatf("v%0d_vd_last", i), vdl, v.vdl);
            chk($sformatf("v%0d_cnt_last", i), cntl, v.cntl);
            chk($sformatf("v%0d_store", i), int'(sok), 1);
            chk($sformatf("v%0d_ready_after", i), int'(inst_ready), 1);
            chk($sformatf("v%0d_valid_after", i), int'(uop_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev[4];
        int ef[4];
        int es[4];
        int ec[4];
        int n, vd0, vdl, cntl;
        bit ls, sok;

        //          vd     nf    eew   emul  vl      st    ill   n vd0 vdl cntl
        tv[0]  = '{5'd4,  3'd1, 2'd0, 2'd1, 8'd20,  1'b0, 1'b0, 4, 4,  7,  4};
        tv[1]  = '{5'd8,  3'd0, 2'd2, 2'd1, 8'd5,   1'b0, 1'b0, 2, 8,  9,  1};
        tv[2]  = '{5'd8,  3'd0, 2'd2, 2'd3, 8'd5,   1'b1, 1'b0, 2, 8,  9,  1};
        tv[3]  = '{5'd0,  3'd7, 2'd0, 2'd1, 8'd16,  1'b0, 1'b1, 0, 0,  0,  0};
        tv[4]  = '{5'd30, 3'd2, 2'd0, 2'd0, 8'd16,  1'b0, 1'b1, 0, 0,  0,  0};
        tv[5]  = '{5'd0,  3'd0, 2'd3, 2'd0, 8'd4,   1'b0, 1'b1, 0, 0,  0,  0};
        tv[6]  = '{5'd2,  3'd0, 2'd0, 2'd0, 8'd0,   1'b0, 1'b0, 0, 0,  0,  0};
        tv[7]  = '{5'd29, 3'd2, 2'd0, 2'd0, 8'd16,  1'b1, 1'b0, 3, 29, 31, 16};
        tv[8]  = '{5'd0,  3'd3, 2'd1, 2'd1, 8'd128, 1'b0, 1'b0, 8, 0,  7,  8};
        tv[9]  = '{5'd0,  3'd0, 2'd0, 2'd3, 8'd128, 1'b1, 1'b0, 8, 0,  7,  16};
        tv[10] = '{5'd16, 3'd0, 2'd1, 2'd2, 8'd17,  1'b1, 1'b0, 3, 16, 18, 1};

        ev = '{4, 5, 6, 7};
        ef = '{0, 0, 1, 1};
        es = '{0, 16, 0, 16};
        ec = '{16, 4, 16, 4};

        step(); step(); step();
        chk("rst_valid", int'(uop_valid), 0);
        chk("rst_ready", int'(inst_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_illegal", int'(inst_illegal), 0);
        chk("rst_uop_vd", int'(uop_vd), 0);
        chk("rst_uop_cnt", int'(uop_elem_cnt), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_vec(i, tv[i]);
            step();
        end

        // Full uop listing for the two-field, two-register case
        issue(5'd4, 3'd1, 2'd0, 2'd1, 8'd20, 1'b0);
        chk("seq_busy", int'(busy), 1);
        chk("seq_ready_busy", int'(inst_ready), 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq%0d_valid", i), int'(uop_valid), 1);
            chk($sformatf("seq%0d_vd", i), int'(uop_vd), ev[i]);
            chk($sformatf("seq%0d_field", i), int'(uop_field), ef[i]);
            chk($sformatf("seq%0d_start", i), int'(uop_elem_start), es[i]);
            chk($sformatf("seq%0d_cnt", i), int'(uop_elem_cnt), ec[i]);
            chk($sformatf("seq%0d_last", i), int'(uop_last), (i == 3) ? 1 : 0);
            step();
        end
        chk("seq_done_valid", int'(uop_valid), 0);
        chk("seq_done_ready", int'(inst_ready), 1);
        step();

        // Stall three cycles on the second uop
        issue(5'd4, 3'd1, 2'd0, 2'd1, 8'd20, 1'b0);
        step();
        uop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_valid", i), int'(uop_valid), 1);
            chk($sformatf("stall%0d_vd", i), int'(uop_vd), 5);
            chk($sformatf("stall%0d_field", i), int'(uop_field), 0);
            chk($sformatf("stall%0d_start", i), int'(uop_elem_start), 16);
            chk($sformatf("stall%0d_cnt", i), int'(uop_elem_cnt), 4);
            step();
        end
        uop_ready = 1'b1;
        collect(20, 1'b0, n, vd0, vdl, cntl, ls, sok);
        chk("stall_rest_n", n, 3);
        chk("stall_rest_vd0", vd0, 5);
        chk("stall_rest_vdl", vdl, 7);
        chk("stall_rest_last", int'(ls), 1);
        step();

        // Flush after the first uop has been taken
        issue(5'd4, 3'd1, 2'd0, 2'd1, 8'd20, 1'b0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", int'(uop_valid), 0);
        chk("flush_ready", int'(inst_ready), 1);
        chk("flush_busy", int'(busy), 0);
        chk("flush_field", int'(uop_field), 0);
        run_vec(20, tv[1]);
        step();

        // Flush wins over an offered instruction
        inst_vd = 5'd4; inst_nf = 3'd0; inst_eew = 2'd0; inst_emul = 2'd0;
        inst_vl = 8'd4; inst_is_store = 1'b0;
        inst_valid = 1'b1;
        flush = 1'b1;
        step();
        inst_valid = 1'b0;
        flush = 1'b0;
        chk("flushacc_busy", int'(busy), 0);
        chk("flushacc_valid", int'(uop_valid), 0);
        step();

        // Asynchronous reset in the middle of a sequence
        issue(5'd4, 3'd1, 2'd0, 2'd1, 8'd20, 1'b0);
        step();
        chk("prerst_valid", int'(uop_valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(uop_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_vd", int'(uop_vd), 0);
        step();
        rst = 1'b0;
        step();
        chk("postrst_valid", int'(uop_valid), 0);
        chk("postrst_ready", int'(inst_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
